// File: rtl/input_port_buffer_if.sv
// Link/arbiter bundle for the router input port buffer.
// master drives the upstream flit and arbiter pop; slave is the buffer.
interface input_port_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 32
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FLIT_W-1:0] flit_i;
    logic              valid_i;
    logic              credit_o;
    logic              arb_read_i;
    logic [FLIT_W-1:0] flit_o;
    logic [7:0]        arb_address_o;
    logic              empty_o;
    logic              full_o;
    logic [CW-1:0]     count_o;
    logic [1:0]        err_o;

    modport master (
        output flit_i, valid_i, arb_read_i,
        input  credit_o, flit_o, arb_address_o,
        input  empty_o, full_o, count_o, err_o
    );

    modport slave (
        input  flit_i, valid_i, arb_read_i,
        output credit_o, flit_o, arb_address_o,
        output empty_o, full_o, count_o, err_o
    );
endinterface

// File: rtl/input_port_buffer.sv
// Router input port FIFO with credit return to the upstream link.
// Define INPUT_BUFFER_ERR_EN to build sticky overflow/underflow flags.
module input_port_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input_port_buffer_if.slave   bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              r_credit;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_pop   = bus.arb_read_i && !w_empty;
    // A pop on a full buffer frees the slot the push needs.
    assign w_push  = bus.valid_i && (!w_full || w_pop);

    // Flit storage; contents survive reset, only pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= bus.flit_i;
        end
    end

    // Pointers and occupancy; power-of-two depth wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // One credit pulse per accepted pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
        end
    end

`ifdef INPUT_BUFFER_ERR_EN
    logic [1:0] r_err;

    // Sticky flags: bit0 dropped push, bit1 ignored pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 2'b00;
        end else begin
            if (bus.valid_i && !w_push) begin
                r_err[0] <= 1'b1;
            end
            if (bus.arb_read_i && w_empty) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign bus.err_o = r_err;
`else
    assign bus.err_o = 2'b00;
`endif

    assign bus.flit_o        = r_mem[r_rptr];
    assign bus.arb_address_o = r_mem[r_rptr][7:0];
    assign bus.empty_o       = w_empty;
    assign bus.full_o        = w_full;
    assign bus.count_o       = r_count;
    assign bus.credit_o      = r_credit;
endmodule

// File: tb/tb_input_port_buffer.sv
// Bench for input_port_buffer: directed cases plus random traffic
// checked against a queue-based model of the buffer.
module tb_input_port_buffer;
    localparam int DEPTH  = 4;
    localparam int FLIT_W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cred_seen = 0;

    logic [FLIT_W-1:0] q [$];
    logic [1:0]        m_err = 2'b00;
    logic              m_credit = 1'b0;

    input_port_buffer_if #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) bus ();

    input_port_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(bus.count_o), 32'(q.size()));
        chk("empty", 32'(bus.empty_o), 32'(q.size() == 0));
        chk("full", 32'(bus.full_o), 32'(q.size() == DEPTH));
        chk("credit", 32'(bus.credit_o), 32'(m_credit));
`ifdef INPUT_BUFFER_ERR_EN
        chk("err", 32'(bus.err_o), 32'(m_err));
`else
        chk("err", 32'(bus.err_o), 32'd0);
`endif
        if (q.size() != 0) begin
            chk("head", bus.flit_o, q[0]);
            chk("addr", 32'(bus.arb_address_o), 32'(q[0][7:0]));
        end
    endtask

    task automatic step(input logic v, input logic [FLIT_W-1:0] d,
                        input logic rd);
        int  n;
        bit  pop;
        bit  push;
        @(negedge clk);
        bus.valid_i    = v;
        bus.flit_i     = d;
        bus.arb_read_i = rd;
        @(posedge clk);
        n    = q.size();
        pop  = rd && (n > 0);
        push = v && ((n < DEPTH) || pop);
        if (v && !push) m_err[0] = 1'b1;
        if (rd && n == 0) m_err[1] = 1'b1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back(d);
        m_credit = pop;
        #1;
        if (bus.credit_o === 1'b1) cred_seen++;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.valid_i    = 1'b0;
        bus.arb_read_i = 1'b0;
        #2 reset = 1'b1;
        q.delete();
        m_err    = 2'b00;
        m_credit = 1'b0;
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [FLIT_W-1:0] head_before;
        bus.valid_i    = 1'b0;
        bus.arb_read_i = 1'b0;
        bus.flit_i     = '0;
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        // first push right after reset
        step(1'b1, 32'h0000_00A1, 1'b0);
        chk("first_addr", 32'(bus.arb_address_o), 32'hA1);
        chk("first_cnt", 32'(bus.count_o), 32'd1);

        // fill, then overflow
        step(1'b1, 32'h0000_11B2, 1'b0);
        step(1'b1, 32'h0000_22C3, 1'b0);
        step(1'b1, 32'h0000_33D4, 1'b0);
        chk("full_flag", 32'(bus.full_o), 32'd1);
        step(1'b1, 32'hDEAD_BEEF, 1'b0);
        chk("drop_cnt", 32'(bus.count_o), 32'd4);

        // push+pop at full
        head_before = bus.flit_o;
        step(1'b1, 32'h0000_44E5, 1'b1);
        chk("pp_cnt", 32'(bus.count_o), 32'd4);
        chk("pp_adv", 32'(bus.flit_o != head_before), 32'd1);
        chk("pp_cred", 32'(bus.credit_o), 32'd1);
        step(1'b0, '0, 1'b0);
        chk("pp_cred_end", 32'(bus.credit_o), 32'd0);

        // drain, then underflow from a clean state
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        do_reset();
        step(1'b0, '0, 1'b1);
        chk("uf_cred", 32'(bus.credit_o), 32'd0);
        step(1'b1, 32'h0000_00F0, 1'b1);
        chk("e_pp_cnt", 32'(bus.count_o), 32'd1);
        step(1'b0, '0, 1'b1);

        // stream 10 flits through with wrap-around
        do_reset();
        cred_seen = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h0000_5000 + 32'(i), i != 0);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        chk("stream_creds", 32'(cred_seen), 32'd10);

        // random traffic
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom,
                 ($urandom_range(0, 9) < 4));
        end

        // reset with 3 flits buffered, pop on the last edge
        do_reset();
        step(1'b1, 32'h0000_0061, 1'b0);
        step(1'b1, 32'h0000_0062, 1'b0);
        step(1'b1, 32'h0000_0063, 1'b0);
        step(1'b1, 32'h0000_0064, 1'b1);
        chk("pre_rst_cnt", 32'(bus.count_o), 32'd3);
        do_reset();
        chk("post_rst_cnt", 32'(bus.count_o), 32'd0);
        step(1'b1, 32'h0000_0077, 1'b0);
        chk("post_rst_push", 32'(bus.arb_address_o), 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
